// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch over a request/response memory port, holding one PC+instruction for ID.
module if_fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              if_allowin,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  input  logic              id_allowin,
  output logic              if_to_id_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_excp_adel,
  input  logic              flush
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, CANCEL} state_t;
  state_t            state;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] inst_reg;
  logic              adel_reg;
  logic              accept;
  logic              misaligned;
  assign if_allowin     = !flush && (state == IDLE || (state == FULL && id_allowin));
  assign accept         = pc_valid_in && if_allowin;
  assign misaligned     = |pc_in[1:0];
  assign inst_req       = state == REQ;
  assign inst_addr      = pc_reg;
  assign if_to_id_valid = state == FULL;
  assign if_pc          = pc_reg;
  assign if_inst        = inst_reg;
  assign if_excp_adel   = adel_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc_reg   <= '0;
      inst_reg <= '0;
      adel_reg <= 1'b0;
    end else if (flush) begin
      // an accepted request still owes one data_ok, which CANCEL swallows
      case (state)
        REQ:     state <= inst_addr_ok ? CANCEL : IDLE;
        WAIT:    state <= inst_data_ok ? IDLE : CANCEL;
        CANCEL:  state <= inst_data_ok ? IDLE : CANCEL;
        default: state <= IDLE;
      endcase
    end else if (accept) begin
      pc_reg   <= pc_in;
      adel_reg <= misaligned;
      if (misaligned) inst_reg <= '0;
      state    <= misaligned ? FULL : REQ;
    end else begin
      case (state)
        REQ:     if (inst_addr_ok) state <= WAIT;
        WAIT:    if (inst_data_ok) begin
                   inst_reg <= inst_rdata;
                   state    <= FULL;
                 end
        FULL:    if (id_allowin) state <= IDLE;
        CANCEL:  if (inst_data_ok) state <= IDLE;
        default: state <= state;
      endcase
    end
  end
  assert property (@(posedge clk) disable iff (rst) inst_data_ok |-> (state == WAIT || state == CANCEL));
endmodule
